// File: rtl/hgc_vram_sequencer.sv
// Character-period sequencer for the Hercules-compatible display path: generates clk_seq,
// the per-character datapath strobes, and shares the VRAM port between display fetch and one CPU slot.
module hgc_vram_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int TEXT_CYCLES = 18,
    parameter int GRPH_CYCLES = 16,
    parameter int CPU_FIRST   = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_grph_mode,
    input  logic [ADDR_W-2:0] i_disp_addr,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_wdata,
    output logic              o_cpu_busy,
    output logic              o_cpu_ack,
    output logic [7:0]        o_cpu_rdata,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic              o_vram_we,
    output logic [7:0]        o_vram_wdata,
    input  logic [7:0]        i_vram_rdata,
    output logic [4:0]        o_clk_seq,
    output logic              o_vram_read_char,
    output logic              o_vram_read_att,
    output logic              o_charrom_read,
    output logic              o_disp_pipeline,
    output logic              o_crtc_clk
);

    localparam logic [4:0] TEXT_N  = 5'(TEXT_CYCLES);
    localparam logic [4:0] GRPH_N  = 5'(GRPH_CYCLES);
    localparam logic [4:0] FIRST_S = 5'(CPU_FIRST);

    logic [4:0]        r_seq;
    logic              r_mode;
    logic              r_busy;
    logic              r_served;
    logic              r_gnt;
    logic              r_ack;
    logic              r_req_we;
    logic [ADDR_W-1:0] r_req_addr;
    logic [7:0]        r_req_wdata;
    logic [7:0]        r_rdata;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_we;
    logic [7:0]        r_vram_wdata;
    logic              r_read_char;
    logic              r_read_att;
    logic              r_charrom;
    logic              r_pipe;

    logic [4:0]        w_period;
    logic              w_last;
    logic [4:0]        w_next_seq;
    logic              w_grant;
    logic              w_accept;

    // Next position in the period, CPU slot grant and request acceptance.
    always_comb begin
        w_period = r_mode ? GRPH_N : TEXT_N;
        w_last   = (r_seq == (w_period - 5'd1));
        if (w_last) begin
            w_next_seq = 5'd0;
        end else begin
            w_next_seq = r_seq + 5'd1;
        end
        // A request accepted during its own ack cycle must wait: r_served blocks a second slot.
        w_grant  = r_busy && !r_served && (w_next_seq >= FIRST_S) &&
                   (w_next_seq <= (w_period - 5'd3));
        w_accept = i_cpu_req && (!r_busy || r_ack);
    end

    // Sequencer, strobes, VRAM port mux and CPU handshake, all registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seq        <= 5'd0;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_served     <= 1'b0;
            r_gnt        <= 1'b0;
            r_ack        <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= 8'd0;
            r_rdata      <= 8'd0;
            r_vram_addr  <= '0;
            r_vram_we    <= 1'b0;
            r_vram_wdata <= 8'd0;
            r_read_char  <= 1'b0;
            r_read_att   <= 1'b0;
            r_charrom    <= 1'b0;
            r_pipe       <= 1'b0;
        end else begin
            r_seq <= w_next_seq;
            if (w_last) begin
                r_mode <= i_grph_mode;
            end

            r_read_char <= (w_next_seq == 5'd1);
            r_read_att  <= (w_next_seq == 5'd3);
            r_charrom   <= (w_next_seq == 5'd4);
            r_pipe      <= (w_next_seq == (w_period - 5'd1));

            if (w_next_seq == 5'd0) begin
                r_served <= 1'b0;
            end else if (w_grant) begin
                r_served <= 1'b1;
            end

            r_gnt     <= w_grant;
            r_vram_we <= w_grant && r_req_we;
            if (w_grant) begin
                r_vram_addr  <= r_req_addr;
                r_vram_wdata <= r_req_wdata;
            end else if (w_next_seq == 5'd0) begin
                r_vram_addr <= {i_disp_addr, 1'b0};
            end else if (w_next_seq == 5'd2) begin
                r_vram_addr <= {i_disp_addr, 1'b1};
            end else begin
                r_vram_addr <= r_vram_addr;
            end

            // VRAM data for the grant-cycle address is present during the grant cycle.
            r_ack <= r_gnt;
            if (r_gnt && !r_req_we) begin
                r_rdata <= i_vram_rdata;
            end

            if (w_accept) begin
                r_busy      <= 1'b1;
                r_req_we    <= i_cpu_we;
                r_req_addr  <= i_cpu_addr;
                r_req_wdata <= i_cpu_wdata;
            end else if (r_ack) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_clk_seq        = r_seq;
    assign o_cpu_busy       = r_busy;
    assign o_cpu_ack        = r_ack;
    assign o_cpu_rdata      = r_rdata;
    assign o_vram_addr      = r_vram_addr;
    assign o_vram_we        = r_vram_we;
    assign o_vram_wdata     = r_vram_wdata;
    assign o_vram_read_char = r_read_char;
    assign o_vram_read_att  = r_read_att;
    assign o_charrom_read   = r_charrom;
    assign o_disp_pipeline  = r_pipe;
    assign o_crtc_clk       = r_pipe;

endmodule

// File: tb/tb_hgc_vram_sequencer.sv
// Self-checking bench for hgc_vram_sequencer: cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hgc_vram_sequencer;

    logic        clk = 1'b0;
    logic        reset, grph, req, we;
    logic [14:0] disp;
    logic [15:0] caddr;
    logic [7:0]  cwdata;
    logic        busy, ack, vwe, rchar, ratt, crom, pipe, crtc;
    logic [7:0]  rdata, vwdata, vrdata;
    logic [15:0] vaddr;
    logic [4:0]  seq;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hgc_vram_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_grph_mode(grph), .i_disp_addr(disp),
        .i_cpu_req(req), .i_cpu_we(we), .i_cpu_addr(caddr), .i_cpu_wdata(cwdata),
        .o_cpu_busy(busy), .o_cpu_ack(ack), .o_cpu_rdata(rdata),
        .o_vram_addr(vaddr), .o_vram_we(vwe), .o_vram_wdata(vwdata), .i_vram_rdata(vrdata),
        .o_clk_seq(seq), .o_vram_read_char(rchar), .o_vram_read_att(ratt),
        .o_charrom_read(crom), .o_disp_pipeline(pipe), .o_crtc_clk(crtc)
    );

    function automatic logic [7:0] vram_data(input logic [15:0] a);
        return (a == 16'h0100) ? 8'hA5 : (a[7:0] ^ a[15:8]);
    endfunction

    assign vrdata = vram_data(vaddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model state describes what must be visible during the current clock cycle.
    int          m_seq, m_len, nseq;
    bit          m_busy, m_ack, m_gnt, m_served, m_we, m_lwe, acc, g, old_ack;
    logic [15:0] m_vaddr, m_laddr;
    logic [7:0]  m_wdata, m_lwdata, m_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_seq = 0; m_len = 18; m_busy = 0; m_ack = 0; m_gnt = 0; m_served = 0;
            m_we = 0; m_lwe = 0; m_vaddr = 0; m_laddr = 0; m_wdata = 0; m_lwdata = 0; m_rdata = 0;
        end else begin
            old_ack = m_ack;
            acc = req && (!m_busy || m_ack);
            if (m_seq == m_len - 1) begin
                nseq = 0;
                m_len = grph ? 16 : 18;
                m_served = 0;
            end else begin
                nseq = m_seq + 1;
            end
            g = m_busy && !m_served && (nseq >= 6) && (nseq <= m_len - 3);
            if (m_gnt && !m_lwe) m_rdata = vram_data(m_laddr);
            m_ack = m_gnt;
            m_gnt = g;
            m_we  = g && m_lwe;
            if (g) begin
                m_vaddr = m_laddr; m_wdata = m_lwdata; m_served = 1;
            end else if (nseq == 0) begin
                m_vaddr = {disp, 1'b0};
            end else if (nseq == 2) begin
                m_vaddr = {disp, 1'b1};
            end
            if (acc) begin
                m_busy = 1; m_lwe = we; m_laddr = caddr; m_lwdata = cwdata;
            end else if (old_ack) begin
                m_busy = 0;
            end
            m_seq = nseq;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("clk_seq", seq, m_seq);
            check("read_char", rchar, m_seq == 1);
            check("read_att", ratt, m_seq == 3);
            check("charrom_read", crom, m_seq == 4);
            check("disp_pipeline", pipe, (m_seq == m_len - 1) && (m_seq != 0));
            check("crtc_clk", crtc, (m_seq == m_len - 1) && (m_seq != 0));
            check("cpu_busy", busy, m_busy);
            check("cpu_ack", ack, m_ack);
            check("cpu_rdata", rdata, m_rdata);
            check("vram_addr", vaddr, m_vaddr);
            check("vram_we", vwe, m_we);
            check("vram_wdata", vwdata, m_wdata);
        end
    end

    task automatic wait_seq(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_seq != k && n < 60);
        if (m_seq != k) begin
            n_chk++; n_err++;
            $display("FAIL wait_seq timeout waiting for %0d", k);
        end
    endtask

    task automatic cpu_pulse(input logic w, input logic [15:0] a, input logic [7:0] d);
        req = 1'b1; we = w; caddr = a; cwdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    int c_rc, c_ra, c_cr, c_ct, crtc_at, c_ack, c_we, n;

    initial begin
        reset = 1'b1; grph = 1'b0; disp = 15'h1234; req = 1'b0; we = 1'b0;
        caddr = 16'h0000; cwdata = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_seq", seq, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_vaddr", vaddr, 16'h0000);
        check("rst_we", vwe, 0);
        reset = 1'b0;

        // Text period, no CPU traffic
        wait_seq(0);
        check("disp_addr_seq0", vaddr, 16'h2468);
        c_rc = 0; c_ra = 0; c_cr = 0; c_ct = 0; crtc_at = -1;
        for (int i = 0; i < 18; i++) begin
            if (i == 2) check("disp_addr_seq2", vaddr, 16'h2469);
            c_rc += int'(rchar); c_ra += int'(ratt); c_cr += int'(crom);
            if (crtc) begin c_ct++; crtc_at = int'(seq); end
            @(negedge clk);
        end
        check("read_char_cnt", c_rc, 1);
        check("read_att_cnt", c_ra, 1);
        check("charrom_cnt", c_cr, 1);
        check("crtc_cnt", c_ct, 1);
        check("crtc_pos", crtc_at, 17);

        // CPU read requested at seq2
        wait_seq(2);
        cpu_pulse(1'b0, 16'h0100, 8'h00);
        check("rd_busy_seq3", busy, 1);
        wait_seq(6);
        check("rd_grant_addr", vaddr, 16'h0100);
        check("rd_grant_we", vwe, 0);
        @(negedge clk);
        check("rd_ack", ack, 1);
        check("rd_data", rdata, 8'hA5);
        check("rd_busy_ack", busy, 1);
        @(negedge clk);
        check("rd_busy_clr", busy, 0);
        check("rd_ack_clr", ack, 0);

        // CPU write at seq16 deferred to next period
        wait_seq(16);
        cpu_pulse(1'b1, 16'h0200, 8'h3C);
        c_we = 0; n = 0;
        while (m_seq != 6 && n < 40) begin
            c_we += int'(vwe);
            @(negedge clk);
            n++;
        end
        check("wr_no_early_we", c_we, 0);
        check("wr_seq", seq, 6);
        check("wr_we", vwe, 1);
        check("wr_addr", vaddr, 16'h0200);
        check("wr_data", vwdata, 8'h3C);

        // Mode switch mid-period
        wait_seq(10);
        grph = 1'b1;
        wait_seq(17);
        check("ms_old_end", seq, 17);
        @(negedge clk);
        check("ms_wrap0", seq, 0);
        wait_seq(15);
        check("ms_crtc15", crtc, 1);
        @(negedge clk);
        check("ms_wrap15", seq, 0);

        // Second request while busy is ignored
        wait_seq(2);
        cpu_pulse(1'b0, 16'h0100, 8'h00);
        wait_seq(4);
        cpu_pulse(1'b1, 16'h0300, 8'h55);
        c_ack = 0; c_we = 0;
        for (int i = 0; i < 32; i++) begin
            c_ack += int'(ack); c_we += int'(vwe);
            @(negedge clk);
        end
        check("busy_ign_acks", c_ack, 1);
        check("busy_ign_we", c_we, 0);

        // Request in the ack cycle is accepted and served next period
        wait_seq(2);
        cpu_pulse(1'b0, 16'h0100, 8'h00);
        wait_seq(7);
        check("ackreq_ack", ack, 1);
        cpu_pulse(1'b1, 16'h0400, 8'h77);
        check("ackreq_busy", busy, 1);
        wait_seq(6);
        check("ackreq_we", vwe, 1);
        check("ackreq_addr", vaddr, 16'h0400);
        check("ackreq_data", vwdata, 8'h77);

        // Reset on the grant edge aborts the access
        wait_seq(2);
        cpu_pulse(1'b0, 16'h0100, 8'h00);
        wait_seq(5);
        reset = 1'b1;
        @(negedge clk);
        check("rstg_seq", seq, 0);
        check("rstg_busy", busy, 0);
        check("rstg_ack", ack, 0);
        check("rstg_we", vwe, 0);
        reset = 1'b0;
        c_ack = 0; c_we = 0;
        for (int i = 0; i < 20; i++) begin
            c_ack += int'(ack); c_we += int'(vwe);
            @(negedge clk);
        end
        check("rstg_no_ack", c_ack, 0);
        check("rstg_no_we", c_we, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
